// File: rtl/dma_host_initiator_if.sv
// -----------------------------------------------------------------------------
// dma_host_initiator_if
// Bundles the beat streams and both Avalon-MM ports of the DMA host initiator.
//   in_valid/in_ready/in_data        host-to-NPU beat stream (512-bit beats)
//   out_valid/out_ready/out_data     NPU-to-host beat stream (512-bit beats)
//   avm_address/chipselect/clken     read-port request, avm_readdata response
//   avm2_address/write/chipselect/   write-port request with 512-bit data and
//   clken/writedata/byteenable       64-bit byte enables
// modport master : the initiator side (dma_host_initiator)
// modport slave  : the host memory / stream side
// -----------------------------------------------------------------------------
interface dma_host_initiator_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [13:0]  avm_address;
  logic         avm_chipselect;
  logic         avm_clken;
  logic [511:0] avm_readdata;
  logic [13:0]  avm2_address;
  logic         avm2_write;
  logic         avm2_chipselect;
  logic         avm2_clken;
  logic [511:0] avm2_writedata;
  logic [63:0]  avm2_byteenable;

  modport master (
    input  in_valid, in_data, out_ready, avm_readdata,
    output in_ready, out_valid, out_data,
    output avm_address, avm_chipselect, avm_clken,
    output avm2_address, avm2_write, avm2_chipselect, avm2_clken,
    output avm2_writedata, avm2_byteenable
  );

  modport slave (
    output in_valid, in_data, out_ready, avm_readdata,
    input  in_ready, out_valid, out_data,
    input  avm_address, avm_chipselect, avm_clken,
    input  avm2_address, avm2_write, avm2_chipselect, avm2_clken,
    input  avm2_writedata, avm2_byteenable
  );
endinterface

// File: rtl/dma_host_initiator.sv
// -----------------------------------------------------------------------------
// dma_host_initiator
// Polls the host status register, streams host-to-NPU beats into the host
// double buffer (write port) and drains NPU-to-host beats from it (read port).
// Half-buffer k, beat i lives at 0x400 + k*0x1000 + i; status at 0x2404.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   bus            dma_host_initiator_if.master (streams + both AVMM ports)
//   blocks_written completed half-buffers written (wraps)
//   blocks_read    completed half-buffers read (wraps)
//   busy           FSM not in IDLE
// Build option: define DMA_INIT_SOFT_RST_EN to issue a write of 0 to the
// host soft-reset register (0x2408) once after every reset, before polling.
// -----------------------------------------------------------------------------
module dma_host_initiator #(
  parameter int RD_LAT    = 2,
  parameter int BUF_BEATS = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  dma_host_initiator_if.master   bus,
  output logic [15:0]            blocks_written,
  output logic [15:0]            blocks_read,
  output logic                   busy
);

  localparam logic [13:0] BUF_BASE    = 14'h0400;
  localparam logic [13:0] STATUS_ADDR = 14'h2404;
  localparam logic [13:0] SRST_ADDR   = 14'h2408;
  localparam logic [11:0] LAST_BEAT   = 12'(BUF_BEATS - 1);
  localparam logic [7:0]  RD_LAT_C    = 8'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE, SRST, POLL_REQ, POLL_WAIT, WRITE, READ_REQ, READ_WAIT, READ_OUT
  } state_e;

  state_e        state_q, state_d;
  logic          wb_ptr_q, wb_ptr_d;
  logic          rb_ptr_q, rb_ptr_d;
  logic [11:0]   wr_beat_q, wr_beat_d;
  logic [11:0]   rd_beat_q, rd_beat_d;
  logic [15:0]   blocks_wr_q, blocks_wr_d;
  logic [15:0]   blocks_rd_q, blocks_rd_d;
  logic [7:0]    lat_q, lat_d;
  logic [511:0]  out_data_q, out_data_d;
  logic [1:0]    wr_ready_bits;
  logic [1:0]    rd_valid_bits;

  // Half-buffer select lands on address bit 12 (stride 0x1000).
  function automatic logic [13:0] buf_addr(input logic ptr, input logic [11:0] beat);
    return BUF_BASE + {1'b0, ptr, beat};
  endfunction

  assign wr_ready_bits  = bus.avm_readdata[1:0];
  assign rd_valid_bits  = bus.avm_readdata[17:16];
  assign bus.out_data   = out_data_q;
  assign blocks_written = blocks_wr_q;
  assign blocks_read    = blocks_rd_q;
  assign busy           = (state_q != IDLE);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wb_ptr_q    <= 1'b0;
      rb_ptr_q    <= 1'b0;
      wr_beat_q   <= 12'd0;
      rd_beat_q   <= 12'd0;
      blocks_wr_q <= 16'd0;
      blocks_rd_q <= 16'd0;
      lat_q       <= 8'd0;
      out_data_q  <= 512'd0;
    end else begin
      state_q     <= state_d;
      wb_ptr_q    <= wb_ptr_d;
      rb_ptr_q    <= rb_ptr_d;
      wr_beat_q   <= wr_beat_d;
      rd_beat_q   <= rd_beat_d;
      blocks_wr_q <= blocks_wr_d;
      blocks_rd_q <= blocks_rd_d;
      lat_q       <= lat_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d     = state_q;
    wb_ptr_d    = wb_ptr_q;
    rb_ptr_d    = rb_ptr_q;
    wr_beat_d   = wr_beat_q;
    rd_beat_d   = rd_beat_q;
    blocks_wr_d = blocks_wr_q;
    blocks_rd_d = blocks_rd_q;
    lat_d       = lat_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
`ifdef DMA_INIT_SOFT_RST_EN
        state_d = SRST;
        lat_d   = 8'd0;
`else
        state_d = POLL_REQ;
`endif
      end
      SRST: begin
`ifdef DMA_INIT_SOFT_RST_EN
        // lat_q==0 is the strobe cycle, then two idle cycles.
        if (lat_q == 8'd2) begin
          state_d = POLL_REQ;
        end else begin
          lat_d = lat_q + 8'd1;
        end
`else
        state_d = POLL_REQ;
`endif
      end
      POLL_REQ: begin
        state_d = POLL_WAIT;
        lat_d   = 8'd1;
      end
      POLL_WAIT: begin
        if (lat_q == RD_LAT_C) begin
          // Draining the NPU output takes priority over accepting new input.
          if (rd_valid_bits[rb_ptr_q]) begin
            state_d = READ_REQ;
          end else if (wr_ready_bits[wb_ptr_q] && bus.in_valid) begin
            state_d = WRITE;
          end else begin
            state_d = POLL_REQ;
          end
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      WRITE: begin
        // Only accepted beats advance; a gap never closes the block.
        if (bus.in_valid) begin
          if (wr_beat_q == LAST_BEAT) begin
            wr_beat_d   = 12'd0;
            wb_ptr_d    = ~wb_ptr_q;
            blocks_wr_d = blocks_wr_q + 16'd1;
            state_d     = POLL_REQ;
          end else begin
            wr_beat_d = wr_beat_q + 12'd1;
          end
        end else begin
          state_d = WRITE;
        end
      end
      READ_REQ: begin
        state_d = READ_WAIT;
        lat_d   = 8'd1;
      end
      READ_WAIT: begin
        if (lat_q == RD_LAT_C) begin
          out_data_d = bus.avm_readdata;
          state_d    = READ_OUT;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      READ_OUT: begin
        if (bus.out_ready) begin
          if (rd_beat_q == LAST_BEAT) begin
            rd_beat_d   = 12'd0;
            rb_ptr_d    = ~rb_ptr_q;
            blocks_rd_d = blocks_rd_q + 16'd1;
            state_d     = POLL_REQ;
          end else begin
            rd_beat_d = rd_beat_q + 12'd1;
            state_d   = READ_REQ;
          end
        end else begin
          state_d = READ_OUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobe and handshake outputs, decoded from the current state only.
  always_comb begin
    bus.in_ready        = 1'b0;
    bus.out_valid       = 1'b0;
    bus.avm_address     = 14'd0;
    bus.avm_chipselect  = 1'b0;
    bus.avm_clken       = 1'b0;
    bus.avm2_address    = 14'd0;
    bus.avm2_write      = 1'b0;
    bus.avm2_chipselect = 1'b0;
    bus.avm2_clken      = 1'b0;
    bus.avm2_writedata  = 512'd0;
    bus.avm2_byteenable = 64'd0;
    case (state_q)
      POLL_REQ: begin
        bus.avm_address    = STATUS_ADDR;
        bus.avm_chipselect = 1'b1;
        bus.avm_clken      = 1'b1;
      end
      READ_REQ: begin
        bus.avm_address    = buf_addr(rb_ptr_q, rd_beat_q);
        bus.avm_chipselect = 1'b1;
        bus.avm_clken      = 1'b1;
      end
      WRITE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          bus.avm2_address    = buf_addr(wb_ptr_q, wr_beat_q);
          bus.avm2_write      = 1'b1;
          bus.avm2_chipselect = 1'b1;
          bus.avm2_clken      = 1'b1;
          bus.avm2_writedata  = bus.in_data;
          bus.avm2_byteenable = {64{1'b1}};
        end else begin
          bus.avm2_write = 1'b0;
        end
      end
      READ_OUT: begin
        bus.out_valid = 1'b1;
      end
      SRST: begin
`ifdef DMA_INIT_SOFT_RST_EN
        if (lat_q == 8'd0) begin
          bus.avm2_address    = SRST_ADDR;
          bus.avm2_write      = 1'b1;
          bus.avm2_chipselect = 1'b1;
          bus.avm2_clken      = 1'b1;
          bus.avm2_byteenable = {64{1'b1}};
        end else begin
          bus.avm2_write = 1'b0;
        end
`endif
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/dma_host_initiator.md
DMA_HOST_INITIATOR -- requirements
Module: dma_host_initiator

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 2: cycles from read-port chipselect to valid avm_readdata.
REQ-002 The block SHALL have parameter BUF_BEATS, default 4096: beats per half-buffer; only 4096 is supported, because the buffer releases on offset 0xFFF.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- in_valid / in_ready / in_data  in/out/in  1/1/512  host-to-NPU beat stream.
- out_valid / out_ready / out_data  out/in/out  1/1/512  NPU-to-host beat stream.
- avm_address / avm_chipselect / avm_clken  out  14/1/1  read-port request.
- avm_readdata  in  512  read-port data.
- avm2_address / avm2_write / avm2_chipselect / avm2_clken  out  14/1/1/1  write-port request.
- avm2_writedata / avm2_byteenable  out  512/64  write-port payload.
- blocks_written / blocks_read  out  16/16  completed half-buffer counts.
- busy  out  1  FSM not in IDLE.

Function
REQ-005 The host address map SHALL be:
- half-buffer k, beat i = 0x400 + k*0x1000 + i;
- status register = 0x2404 (read port);
- soft reset = 0x2408 (write port).
REQ-006 Status word bit assignment SHALL be:
- [1:0] write_buffer_ready;
- [17:16] read_buffer_valid;
- [33:32] write_buffer_valid;
- [49:48] read_buffer_ready.
REQ-007 The FSM states SHALL be IDLE, SRST, POLL_REQ, POLL_WAIT, WRITE, READ_REQ, READ_WAIT, READ_OUT.
REQ-008 IDLE SHALL go to POLL_REQ on the next cycle.
REQ-009 POLL_REQ SHALL assert avm_chipselect=avm_clken=1 for exactly one cycle with avm_address=0x2404.
REQ-010 POLL_WAIT SHALL capture avm_readdata exactly RD_LAT cycles after the POLL_REQ cycle.
REQ-011 Dispatch after a poll SHALL use this priority:
- read_buffer_valid[rb_ptr]=1 -> READ_REQ;
- else write_buffer_ready[wb_ptr]=1 and in_valid=1 -> WRITE;
- else -> POLL_REQ.
REQ-012 WRITE SHALL drive in_ready=1.
- Each in_valid&&in_ready cycle issues one write: avm2_write/chipselect/clken=1, byteenable all ones, data=in_data, address per REQ-005.
- The beat counter increments per accepted beat only; in_valid=0 stalls without a write strobe.
REQ-013 After beat 4095 is accepted, the block SHALL toggle wb_ptr, increment blocks_written (wrapping 0xFFFF->0) and return to POLL_REQ.
REQ-014 READ_REQ SHALL issue one read (chipselect/clken=1, address per REQ-005) and move to READ_WAIT.
REQ-015 READ_WAIT SHALL register avm_readdata into out_data exactly RD_LAT cycles after the request and go to READ_OUT.
REQ-016 READ_OUT SHALL hold out_valid=1 until out_ready=1.
- If beats remain, it goes to READ_REQ.
- After beat 4095, it toggles rb_ptr, increments blocks_read and goes to POLL_REQ.
REQ-017 At most one read request SHALL be outstanding; no read is issued while out_valid=1.
REQ-018 Both AVMM ports SHALL never be strobed in the same cycle.
REQ-019 Outside their owning states, every strobe output and in_ready/out_valid SHALL be 0.
REQ-020 in_ready SHALL be 0 in every state except WRITE.
REQ-021 Partial blocks SHALL remain pending: an in_valid gap mid-block never ends the block early.

Reset
REQ-022 On reset the block SHALL clear all strobes, in_ready, out_valid, busy, wb_ptr, rb_ptr, beat counters and block counters.
- out_data SHALL reset to 0 and the FSM to IDLE.
REQ-023 Reset asserted mid-block SHALL abort the block with no further strobes from the next cycle; the partially written half-buffer is not counted.

Configuration
REQ-024 With DMA_INIT_SOFT_RST_EN defined, IDLE after reset SHALL go to SRST.
- SRST issues one write to 0x2408 (data 0, byteenable all ones), then waits 2 cycles before POLL_REQ.
REQ-025 Without DMA_INIT_SOFT_RST_EN, SRST SHALL be unreachable and no write to 0x2408 is ever issued.

Verification
REQ-026 Status 0x3 ready, in_valid held high -> 4096 writes to 0x400..0x13FF on consecutive cycles, then blocks_written=1, next block targets 0x1400.
REQ-027 in_valid toggled every other cycle during WRITE -> exactly 4096 strobes, addresses contiguous, no strobe when in_valid=0.
REQ-028 Status with read_buffer_valid=2'b01 and write_buffer_ready=2'b11 -> read drain of 0x400..0x13FF runs first; out_data equals model contents; blocks_read=1.
REQ-029 out_ready low for 10 cycles at beat 7 -> out_valid and out_data held stable, no new read strobe, beat 8 read issued after the handshake.
REQ-030 Reset at write beat 100 -> strobes stop the next cycle, counters 0, first post-reset write at 0x400 (with macro: preceded by the 0x2408 write).
REQ-031 Status with write_buffer_ready=0 and read_buffer_valid=0 -> continuous POLL_REQ/POLL_WAIT cycling, in_ready=0, no write-port strobes.
